// File: rtl/scv_vram_arb_pkg.sv
// Shared types for the SCV video RAM arbiter: access owner, FSM state and
// the default starvation threshold.
package scv_vram_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } own_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = 4;

endpackage

// File: rtl/scv_vram_arb_starve_ctr.sv
// Saturating up-counter with synchronous clear; tracks how long video has
// been kept waiting behind the CPU.
module scv_starve_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && (cnt != {W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/scv_vram_arb.sv
// Two-port (CPU read/write, video read-only) arbiter in front of a single
// synchronous 8-bit RAM; one access every two cycles, CPU priority with a
// starvation override for video.
module scv_vram_arb
  import scv_vram_arb_pkg::*;
#(
  parameter int AW         = 13,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_A,
  input  logic [7:0]    CPU_DO,
  output logic [7:0]    CPU_DI,
  output logic          CPU_ACK,
  input  logic          VID_REQ,
  input  logic [AW-1:0] VID_A,
  output logic [7:0]    VID_DI,
  output logic          VID_ACK,
  output logic [AW-1:0] RAM_A,
  output logic          RAM_WE,
  output logic [7:0]    RAM_D,
  input  logic [7:0]    RAM_Q
);

  state_e              state;
  own_e                own;
  logic                we_q;
  logic [7:0]          cpu_di_q;
  logic [7:0]          vid_di_q;
  logic [STARVE_W-1:0] starve_cnt;

  logic vid_outranks;
  logic cpu_elig;
  logic vid_elig;
  logic grant_cpu;
  logic grant_vid;
  logic vid_busy;

  // Eligibility already folds in priority, so at most one side is eligible.
  // In COMPLETE the owner's REQ is still up for its ACK cycle: if it would
  // win, nobody is granted and the FSM drops to IDLE.
  assign vid_outranks = starve_cnt >= STARVE_W'(STARVE_MAX);
  assign cpu_elig     = CPU_REQ && !(VID_REQ && vid_outranks);
  assign vid_elig     = VID_REQ && (!CPU_REQ || vid_outranks);
  assign vid_busy     = (state != ST_IDLE) && (own == OWN_VID);

  always_comb begin
    grant_cpu = 1'b0;
    grant_vid = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_cpu = cpu_elig;
        grant_vid = vid_elig;
      end
      ST_COMPLETE: begin
        grant_cpu = cpu_elig && (own == OWN_VID);
        grant_vid = vid_elig && (own == OWN_CPU);
      end
      default: ;
    endcase
  end

  scv_starve_ctr #(.W(STARVE_W)) u_starve (
    .clk (CLK),
    .rst (RESET),
    .inc (VID_REQ && !vid_busy && !grant_vid),
    .clr (!VID_REQ || grant_vid),
    .cnt (starve_cnt)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      own      <= OWN_CPU;
      we_q     <= 1'b0;
      RAM_A    <= '0;
      RAM_D    <= '0;
      RAM_WE   <= 1'b0;
      CPU_ACK  <= 1'b0;
      VID_ACK  <= 1'b0;
      cpu_di_q <= '0;
      vid_di_q <= '0;
    end else begin
      CPU_ACK <= 1'b0;
      VID_ACK <= 1'b0;
      RAM_WE  <= 1'b0;
      case (state)
        ST_IDLE, ST_COMPLETE: begin
          if (state == ST_COMPLETE && !we_q) begin
            if (own == OWN_CPU) cpu_di_q <= RAM_Q;
            else                vid_di_q <= RAM_Q;
          end
          if (grant_cpu) begin
            state  <= ST_ISSUE;
            own    <= OWN_CPU;
            we_q   <= CPU_WE;
            RAM_A  <= CPU_A;
            RAM_D  <= CPU_DO;
            RAM_WE <= CPU_WE;
          end else if (grant_vid) begin
            state  <= ST_ISSUE;
            own    <= OWN_VID;
            we_q   <= 1'b0;
            RAM_A  <= VID_A;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state   <= ST_COMPLETE;
          CPU_ACK <= (own == OWN_CPU);
          VID_ACK <= (own == OWN_VID);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read data lands on RAM_Q during the ACK cycle; show it then and keep the
  // captured copy afterwards. The select is purely registered state.
  assign CPU_DI = (CPU_ACK && !we_q) ? RAM_Q : cpu_di_q;
  assign VID_DI = (VID_ACK && !we_q) ? RAM_Q : vid_di_q;

endmodule

// File: tb/tb_scv_vram_arb.sv
// Directed bench for scv_vram_arb with a behavioural synchronous RAM.
module tb_scv_vram_arb;
  localparam int AW = 13;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          CPU_REQ = 1'b0, CPU_WE = 1'b0;
  logic [AW-1:0] CPU_A = '0;
  logic [7:0]    CPU_DO = '0;
  logic [7:0]    CPU_DI;
  logic          CPU_ACK;
  logic          VID_REQ = 1'b0;
  logic [AW-1:0] VID_A = '0;
  logic [7:0]    VID_DI;
  logic          VID_ACK;
  logic [AW-1:0] RAM_A;
  logic          RAM_WE;
  logic [7:0]    RAM_D;
  logic [7:0]    RAM_Q;

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_a = '0;
  logic [7:0]    pre_d = '0;

  int n_chk = 0;
  int n_fail = 0;
  int we_cycles = 0;
  int overlap = 0;

  always #5 CLK = ~CLK;

  scv_vram_arb #(.AW(AW), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_DO(CPU_DO),
    .CPU_DI(CPU_DI), .CPU_ACK(CPU_ACK),
    .VID_REQ(VID_REQ), .VID_A(VID_A), .VID_DI(VID_DI), .VID_ACK(VID_ACK),
    .RAM_A(RAM_A), .RAM_WE(RAM_WE), .RAM_D(RAM_D), .RAM_Q(RAM_Q)
  );

  always @(posedge CLK) begin
    if (pre_we)      mem[pre_a] <= pre_d;
    else if (RAM_WE) mem[RAM_A] <= RAM_D;
    RAM_Q <= mem[RAM_A];
  end

  always @(posedge CLK) begin
    if (RAM_WE) we_cycles++;
    if (CPU_ACK && VID_ACK) overlap++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  task automatic wait_ack(input bit vid, output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (vid ? VID_ACK : CPU_ACK) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 RESET = 1'b1;
    #2;
    n_chk++;
    if ({CPU_ACK, VID_ACK, RAM_WE, RAM_A, RAM_D, CPU_DI, VID_DI} !== 40'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0",
               {CPU_ACK, VID_ACK, RAM_WE, RAM_A, RAM_D, CPU_DI, VID_DI});
    end
    poke(13'h0123, 8'h5A);
    poke(13'h1FFF, 8'h00);
    poke(13'h0055, 8'h11);
    poke(13'h0010, 8'h99);
    poke(13'h0020, 8'h77);
    for (int i = 0; i < 16; i++) poke(13'(i), 8'(8'h80 + 3 * i));
    RESET = 1'b0;
  endtask

  task automatic test_cpu_read();
    int lat, we0;
    we0 = we_cycles;
    CPU_WE = 1'b0; CPU_A = 13'h0123; CPU_REQ = 1'b1;
    wait_ack(1'b0, lat);
    n_chk++;
    if (lat !== 2) begin n_fail++; $display("FAIL read_latency: got %0d want 2", lat); end
    n_chk++;
    if (CPU_DI !== 8'h5A) begin n_fail++; $display("FAIL read_data: got %h want 5a", CPU_DI); end
    step();
    CPU_REQ = 1'b0;
    n_chk++;
    if ({CPU_ACK, CPU_DI} !== {1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL read_ack_pulse_hold: got %h want 05a", {CPU_ACK, CPU_DI});
    end
    n_chk++;
    if (we_cycles !== we0) begin n_fail++; $display("FAIL read_no_we: got %0d want %0d", we_cycles, we0); end
  endtask

  task automatic test_cpu_write();
    int lat, we0;
    we0 = we_cycles;
    CPU_WE = 1'b1; CPU_A = 13'h1FFF; CPU_DO = 8'hA5; CPU_REQ = 1'b1;
    step();
    n_chk++;
    if ({RAM_WE, RAM_A, RAM_D} !== {1'b1, 13'h1FFF, 8'hA5}) begin
      n_fail++; $display("FAIL write_issue: got %h want %h", {RAM_WE, RAM_A, RAM_D}, {1'b1, 13'h1FFF, 8'hA5});
    end
    step();
    n_chk++;
    if ({CPU_ACK, RAM_WE} !== 2'b10) begin
      n_fail++; $display("FAIL write_complete: got %b want 10", {CPU_ACK, RAM_WE});
    end
    step();
    CPU_REQ = 1'b0; CPU_A = 13'h0ABC; CPU_DO = 8'hFF;
    step();
    n_chk++;
    if ({RAM_A, RAM_D} !== {13'h1FFF, 8'hA5}) begin
      n_fail++; $display("FAIL ram_hold: got %h want %h", {RAM_A, RAM_D}, {13'h1FFF, 8'hA5});
    end
    n_chk++;
    if (we_cycles - we0 !== 1) begin n_fail++; $display("FAIL write_we_cycles: got %0d want 1", we_cycles - we0); end
    CPU_WE = 1'b0; CPU_A = 13'h1FFF; CPU_REQ = 1'b1;
    wait_ack(1'b0, lat);
    n_chk++;
    if ({lat == 2, CPU_DI} !== {1'b1, 8'hA5}) begin
      n_fail++; $display("FAIL readback: got lat %0d data %h want lat 2 data a5", lat, CPU_DI);
    end
    step();
    CPU_REQ = 1'b0;
  endtask

  // Video alone: 2-cycle latency, then the ACK cycle excludes the owner so
  // the next access is granted from IDLE.
  task automatic test_vid_stream();
    int lat;
    VID_REQ = 1'b1;
    for (int i = 0; i < 16; i++) begin
      VID_A = 13'(i);
      wait_ack(1'b1, lat);
      n_chk++;
      if (lat !== 2) begin n_fail++; $display("FAIL vid_latency[%0d]: got %0d want 2", i, lat); end
      n_chk++;
      if (VID_DI !== 8'(8'h80 + 3 * i)) begin
        n_fail++; $display("FAIL vid_data[%0d]: got %h want %h", i, VID_DI, 8'(8'h80 + 3 * i));
      end
      n_chk++;
      if (dut.starve_cnt !== 4'd0) begin
        n_fail++; $display("FAIL vid_starve[%0d]: got %0d want 0", i, dut.starve_cnt);
      end
      step();
    end
    VID_REQ = 1'b0;
  endtask

  task automatic test_starve();
    logic [31:0] exp_c, exp_v;
    exp_c = (32'd1 << 2) | (32'd1 << 5) | (32'd1 << 9) | (32'd1 << 12) |
            (32'd1 << 16) | (32'd1 << 19) | (32'd1 << 23);
    exp_v = (32'd1 << 7) | (32'd1 << 14) | (32'd1 << 21);
    RESET = 1'b1;
    CPU_WE = 1'b0; CPU_A = 13'h0010; VID_A = 13'h0020;
    CPU_REQ = 1'b1; VID_REQ = 1'b1;
    step();
    RESET = 1'b0;
    for (int s = 1; s <= 23; s++) begin
      step();
      n_chk++;
      if ({CPU_ACK, VID_ACK} !== {exp_c[s], exp_v[s]}) begin
        n_fail++; $display("FAIL starve_acks[step %0d]: got %b want %b", s, {CPU_ACK, VID_ACK}, {exp_c[s], exp_v[s]});
      end
      if (s == 7) begin
        n_chk++;
        if (VID_DI !== 8'h77) begin n_fail++; $display("FAIL starve_vid_data: got %h want 77", VID_DI); end
      end
      if (s == 21) VID_REQ = 1'b0;
    end
    step();
    CPU_REQ = 1'b0;
    n_chk++;
    if (overlap !== 0) begin n_fail++; $display("FAIL ack_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    CPU_WE = 1'b1; CPU_A = 13'h0055; CPU_DO = 8'h3C; CPU_REQ = 1'b1;
    step();
    n_chk++;
    if (RAM_WE !== 1'b1) begin n_fail++; $display("FAIL midrst_issue_we: got %b want 1", RAM_WE); end
    #1 RESET = 1'b1;
    #1;
    n_chk++;
    if ({CPU_ACK, VID_ACK, RAM_WE, RAM_A, RAM_D, CPU_DI, VID_DI} !== 40'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h want 0",
                         {CPU_ACK, VID_ACK, RAM_WE, RAM_A, RAM_D, CPU_DI, VID_DI});
    end
    step();
    step();
    n_chk++;
    if ({CPU_ACK, mem[13'h0055]} !== {1'b0, 8'h11}) begin
      n_fail++; $display("FAIL midrst_aborted: got %h want 011", {CPU_ACK, mem[13'h0055]});
    end
    RESET = 1'b0;
    wait_ack(1'b0, lat);
    n_chk++;
    if ({lat == 2, mem[13'h0055]} !== {1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL midrst_reissue: got lat %0d mem %h want lat 2 mem 3c", lat, mem[13'h0055]);
    end
    step();
    CPU_REQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_vid_stream();
    test_starve();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
